// File: rtl/operand_stack_pkg.sv
// Shared types for the IDIOT operand stack: data word and stack op encodings.
package operand_stack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    STK_NOP  = 3'b000,
    STK_PUSH = 3'b001,
    STK_POP  = 3'b010,
    STK_RED  = 3'b011,
    STK_REPL = 3'b100,
    STK_SWAP = 3'b101,
    STK_CLR  = 3'b110,
    STK_RSVD = 3'b111
  } stk_op_e;

endpackage

// File: rtl/opstack_mem.sv
// Backing store for the stack entries below tos/nos: one write port, one
// combinational read port so POP/RED refill nos in the same cycle.
module opstack_mem
  import operand_stack_pkg::*;
#(
  parameter int WORDS = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t ram [WORDS];

  // NOTE: storage is deliberately not reset; the depth count decides which
  // words are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  assign rdata = ram[raddr];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the alu: tos/nos in registers, deeper entries in opstack_mem.
// Define OPSTACK_CHK_EN to suppress illegal ops and flag them on the sticky err output.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         op,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  tos,
  output logic [WORD_W-1:0]  nos,
  output logic [DEPTH_W-1:0] depth,
  output logic               empty,
  output logic               full,
  output logic               err
);

  localparam int MEM_WORDS = DEPTH - 2;
  localparam int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(DEPTH);

  stk_op_e              op_e;
  word_t                tos_q, nos_q, tos_d, nos_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d, depth_inc, depth_dec;
  logic                 depth_ge2, depth_ge3;
  logic                 illegal;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr, mem_raddr;
  word_t                mem_rdata, nos_refill;

  assign op_e      = stk_op_e'(op);
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DMAX);
  assign depth_ge2 = (depth_q >= DEPTH_W'(2));
  assign depth_ge3 = (depth_q >= DEPTH_W'(3));
  assign depth     = depth_q;

  // Registers may hold stale values after shrinking; mask them by depth so
  // absent slots always read as zero.
  assign tos = empty     ? '0 : tos_q;
  assign nos = depth_ge2 ? nos_q : '0;

  // Count wraps mod DEPTH+1 when unchecked ops over/underflow it.
  assign depth_inc = full  ? '0   : depth_q + DEPTH_W'(1);
  assign depth_dec = empty ? DMAX : depth_q - DEPTH_W'(1);

  assign mem_waddr  = AW'(depth_q - DEPTH_W'(2));
  assign mem_raddr  = AW'(depth_q - DEPTH_W'(3));
  assign nos_refill = depth_ge3 ? mem_rdata : '0;

`ifdef OPSTACK_CHK_EN
  logic err_q;

  always_comb begin
    illegal = 1'b0;
    case (op_e)
      STK_PUSH:          illegal = full;
      STK_POP, STK_REPL: illegal = empty;
      STK_RED, STK_SWAP: illegal = !depth_ge2;
      STK_RSVD:          illegal = 1'b1;
      default:           illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    mem_we  = 1'b0;
    if (!illegal) begin
      case (op_e)
        STK_PUSH: begin
          tos_d   = wdata;
          nos_d   = tos;
          depth_d = depth_inc;
          mem_we  = depth_ge2 && !full;
        end
        STK_POP: begin
          tos_d   = nos;
          nos_d   = nos_refill;
          depth_d = depth_dec;
        end
        STK_RED: begin
          tos_d   = wdata;
          nos_d   = nos_refill;
          depth_d = depth_dec;
        end
        STK_REPL: tos_d = wdata;
        STK_SWAP: begin
          tos_d = nos;
          nos_d = tos;
        end
        STK_CLR: begin
          tos_d   = '0;
          nos_d   = '0;
          depth_d = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
    end
  end

  opstack_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (nos),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack (DEPTH=16); CHK-dependent
// scenarios follow OPSTACK_CHK_EN.
module tb_operand_stack;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, RED = 3'b011;
  localparam logic [2:0] REPL = 3'b100, SWAP = 3'b101, CLR = 3'b110, RSVD = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [15:0] wdata = '0;
  logic [15:0] tos, nos;
  logic [4:0]  depth;
  logic        empty, full, err;

  int tests = 0;
  int fails = 0;

  // Observed state packed as {tos, nos, depth, empty, full, err}.
  logic [39:0] got;
  logic [39:0] exp;
  assign got = {tos, nos, depth, empty, full, err};

  operand_stack #(.DEPTH(16), .DEPTH_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .wdata (wdata),
    .tos   (tos),
    .nos   (nos),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] o, input logic [15:0] d);
    @(negedge clk);
    op    = o;
    wdata = d;
    @(posedge clk);
    #1;
    op    = NOP;
    wdata = 16'hdead;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_state got %h want %h", got, exp); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_push_red_pop();
    do_op(PUSH, 16'd5);
    do_op(PUSH, 16'd7);
    do_op(PUSH, 16'd9);
    exp = {16'd9, 16'd7, 5'd3, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL push3 got %h want %h", got, exp); end
    do_op(RED, 16'd16);
    exp = {16'd16, 16'd5, 5'd2, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL red got %h want %h", got, exp); end
    do_op(POP, 16'd0);
    exp = {16'd5, 16'd0, 5'd1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL pop_after_red got %h want %h", got, exp); end
    do_op(CLR, 16'd0);
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL clr got %h want %h", got, exp); end
  endtask

  task automatic test_fill_drain();
    int t;
    for (int i = 1; i <= 16; i++) do_op(PUSH, 16'(i));
    exp = {16'd16, 16'd15, 5'd16, 1'b0, 1'b1, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL fill got %h want %h", got, exp); end
    for (int i = 1; i <= 16; i++) begin
      do_op(POP, 16'd0);
      t = 16 - i;
      exp = {16'(t), (t >= 2) ? 16'(t - 1) : 16'd0, 5'(t), (t == 0), 1'b0, 1'b0};
      tests++;
      if (got !== exp) begin fails++; $display("FAIL drain_%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_swap_repl();
    do_op(PUSH, 16'd4);
    do_op(PUSH, 16'd3);
    do_op(SWAP, 16'hffff);
    exp = {16'd4, 16'd3, 5'd2, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL swap got %h want %h", got, exp); end
    do_op(REPL, 16'd1);
    exp = {16'd1, 16'd3, 5'd2, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL repl got %h want %h", got, exp); end
    do_op(NOP, 16'd77);
    tests++;
    if (got !== exp) begin fails++; $display("FAIL nop_hold got %h want %h", got, exp); end
    do_op(CLR, 16'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) do_op(PUSH, 16'(i));
    do_op(POP, 16'd0);
    exp = {16'd4, 16'd3, 5'd4, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL b2b_pop1 got %h want %h", got, exp); end
    do_op(POP, 16'd0);
    exp = {16'd3, 16'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL b2b_pop2 got %h want %h", got, exp); end
    do_op(PUSH, 16'd8);
    exp = {16'd8, 16'd3, 5'd4, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL b2b_push got %h want %h", got, exp); end
    do_op(RED, 16'd11);
    exp = {16'd11, 16'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL b2b_red got %h want %h", got, exp); end
    do_op(POP, 16'd0);
    exp = {16'd2, 16'd1, 5'd2, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL b2b_pop3 got %h want %h", got, exp); end
  endtask

`ifdef OPSTACK_CHK_EN
  task automatic test_checks();
    apply_reset();
    do_op(POP, 16'd0);
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b1};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL chk_pop_empty got %h want %h", got, exp); end
    apply_reset();
    for (int i = 1; i <= 16; i++) do_op(PUSH, 16'(i));
    do_op(PUSH, 16'd99);
    exp = {16'd16, 16'd15, 5'd16, 1'b0, 1'b1, 1'b1};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL chk_push_full got %h want %h", got, exp); end
    apply_reset();
    do_op(PUSH, 16'd5);
    do_op(RED, 16'd9);
    exp = {16'd5, 16'd0, 5'd1, 1'b0, 1'b0, 1'b1};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL chk_red_short got %h want %h", got, exp); end
    do_op(CLR, 16'd0);
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b1};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL chk_err_sticky got %h want %h", got, exp); end
  endtask
`else
  task automatic test_wrap();
    apply_reset();
    do_op(POP, 16'd0);
    exp = {16'd0, 16'd0, 5'd16, 1'b0, 1'b1, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL wrap_pop got %h want %h", got, exp); end
    do_op(PUSH, 16'd4);
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL wrap_push got %h want %h", got, exp); end
  endtask
`endif

  task automatic test_reserved();
    apply_reset();
    do_op(PUSH, 16'd6);
    do_op(RSVD, 16'd42);
`ifdef OPSTACK_CHK_EN
    exp = {16'd6, 16'd0, 5'd1, 1'b0, 1'b0, 1'b1};
`else
    exp = {16'd6, 16'd0, 5'd1, 1'b0, 1'b0, 1'b0};
`endif
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reserved_op got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    do_op(PUSH, 16'd1);
    do_op(PUSH, 16'd2);
    @(negedge clk);
    op    = PUSH;
    wdata = 16'd3;
    #2 reset = 1'b1;
    #1;
    exp = {16'd0, 16'd0, 5'd0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL rst_immediate got %h want %h", got, exp); end
    @(posedge clk);
    #1;
    tests++;
    if (got !== exp) begin fails++; $display("FAIL rst_no_commit got %h want %h", got, exp); end
    @(negedge clk);
    reset = 1'b0;
    op    = NOP;
    @(posedge clk);
    #1;
    tests++;
    if (got !== exp) begin fails++; $display("FAIL rst_release got %h want %h", got, exp); end
    do_op(PUSH, 16'd7);
    exp = {16'd7, 16'd0, 5'd1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL rst_then_push got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_push_red_pop();
    test_fill_drain();
    test_swap_repl();
    test_back_to_back();
`ifdef OPSTACK_CHK_EN
    test_checks();
`else
    test_wrap();
`endif
    test_reserved();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
